// File: rtl/ysyx_22060042_pkg.sv
// Shared types for the sriz multi-cycle sequencer: FSM states, halt causes
// and the sequential PC step.
package ysyx_22060042_pkg;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_EBREAK        = 2'd0,
    CAUSE_ILLEGAL       = 2'd1,
    CAUSE_MISALIGN      = 2'd2,
    CAUSE_FETCH_TIMEOUT = 2'd3
  } halt_cause_e;

  localparam int unsigned INST_BYTES = 4;

  // Fall-through PC; wraps silently at 2^32.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] cur_pc);
    return cur_pc + 32'(INST_BYTES);
  endfunction

endpackage

// File: rtl/ysyx_22060042_fetch_wdt.sv
// Fetch watchdog: counts FETCH cycles without an accepted response and flags
// the last allowed cycle; also marks the first cycle of a fetch.
module ysyx_22060042_fetch_wdt #(
  parameter int unsigned FETCH_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic first_o,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FETCH_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count 0 means the request rose this cycle, so no response is accepted yet.
  assign first_o   = (cnt_q == '0);
  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ysyx_22060042_seq_ctrl.sv
// Multi-cycle sequencer for the sriz core: owns PC/IR and walks each
// instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
module ysyx_22060042_seq_ctrl
  import ysyx_22060042_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_resp_valid,
  input  logic [31:0] ifu_resp_inst,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        dec_is_mem,
  input  logic        dec_rd_we,
  input  logic [4:0]  dec_rd,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  output logic        exu_start,
  input  logic        exu_done,
  input  logic        exu_taken,
  input  logic [31:0] exu_target,
  output logic        lsu_req_valid,
  input  logic        lsu_resp_valid,
  output logic        rf_we,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] retired
);

  seq_state_e  state_q, state_d;
  halt_cause_e cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] target_q, target_d;
  logic        taken_q, taken_d;
  logic        start_q, start_d;
  logic        we_q, we_d;

  logic        pc_aligned;
  logic        wdt_first;
  logic        wdt_expired;
  logic        fetch_accept;
  logic        wb_we;

  assign pc_aligned   = (pc_q[1:0] == 2'b00);
  assign fetch_accept = (state_q == FETCH) && pc_aligned && ifu_resp_valid && !wdt_first;
  assign wb_we        = dec_rd_we && (dec_rd != 5'd0);

  ysyx_22060042_fetch_wdt #(
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) u_fetch_wdt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != FETCH),
    .en_i      ((state_q == FETCH) && !fetch_accept),
    .first_o   (wdt_first),
    .expired_o (wdt_expired)
  );

  // start_d / we_d are registered so exu_start and rf_we decode from flops only.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    taken_d   = taken_q;
    target_d  = target_q;
    start_d   = 1'b0;
    we_d      = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (!pc_aligned) begin
          state_d = HALT;
          cause_d = CAUSE_MISALIGN;
        end else if (fetch_accept) begin
          ir_d    = ifu_resp_inst;
          state_d = DECODE;
        end else if (wdt_expired) begin
          state_d = HALT;
          cause_d = CAUSE_FETCH_TIMEOUT;
        end
      end
      DECODE: begin
        if (dec_illegal) begin
          state_d = HALT;
          cause_d = CAUSE_ILLEGAL;
        end else if (dec_ebreak) begin
          state_d   = HALT;
          cause_d   = CAUSE_EBREAK;
          retired_d = retired_q + 32'd1;
        end else begin
          state_d = EXEC;
          start_d = 1'b1;
        end
      end
      EXEC: begin
        if (exu_done) begin
          taken_d  = exu_taken;
          target_d = exu_target;
          if (dec_is_mem) begin
            state_d = MEM;
          end else begin
            state_d = WB;
            we_d    = wb_we;
          end
        end
      end
      MEM: begin
        if (lsu_resp_valid) begin
          state_d = WB;
          we_d    = wb_we;
        end
      end
      WB: begin
        pc_d      = taken_q ? target_q : next_seq_pc(pc_q);
        retired_d = retired_q + 32'd1;
        state_d   = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      cause_q   <= CAUSE_EBREAK;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      taken_q   <= 1'b0;
      start_q   <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      taken_q   <= taken_d;
      start_q   <= start_d;
      we_q      <= we_d;
    end
  end

  // Branch target is pure data: only meaningful once taken_q is set.
  always_ff @(posedge clk) begin
    target_q <= target_d;
  end

  assign ifu_req_valid = (state_q == FETCH) && pc_aligned;
  assign ifu_req_addr  = pc_q;
  assign inst          = ir_q;
  assign pc            = pc_q;
  assign exu_start     = start_q;
  assign lsu_req_valid = (state_q == MEM);
  assign rf_we         = we_q;
  assign halted        = (state_q == HALT);
  assign halt_cause    = cause_q;
  assign retired       = retired_q;

endmodule
